// File: rtl/uart_pkg.sv
// Shared UART definitions for the CPU I/O unit: opcodes, default bit timing
// and the state encodings of the receive-side state machines.
package uart_pkg;

    // Send-path opcode, kept here so both directions decode from one place.
    localparam logic [5:0] OPCODE_SND = 6'b010001;
    localparam logic [5:0] OPCODE_RCV = 6'b010010;

    // 50 MHz system clock, 115200 baud.
    localparam int DEFAULT_CLKS_PER_BIT = 434;

    // Bit-level receiver states.
    typedef enum logic [2:0] {
        IDLE,
        START,
        DATA,
        STOP,
        DRAIN
    } rx_state_t;

    // Instruction-level handshake states.
    typedef enum logic [1:0] {
        C_IDLE,
        C_WAIT,
        C_DONE
    } ctrl_state_t;

endpackage

// File: rtl/receive_control_if.sv
// CPU-side signals of the receive path: instruction decode in, byte and
// status out.
interface receive_control_if;
    logic [5:0] opcode;
    logic       input_sig_rcv;
    logic [7:0] rcv_data;
    logic       rcv_flag;
    logic       rcv_wait;
    logic       frame_err;
    logic       overrun;

    // CPU / datapath side.
    modport master (
        output opcode,
        output input_sig_rcv,
        input  rcv_data,
        input  rcv_flag,
        input  rcv_wait,
        input  frame_err,
        input  overrun
    );

    // Receive block side.
    modport slave (
        input  opcode,
        input  input_sig_rcv,
        output rcv_data,
        output rcv_flag,
        output rcv_wait,
        output frame_err,
        output overrun
    );
endinterface

// File: rtl/uart_rx.sv
// 8N1 deserializer: input synchronizer, bit FSM and bit-period counter.
// byte_valid and stop_err are single-cycle strobes raised on the stop-bit
// sample cycle, so the consumer registers the byte on that same edge.
module uart_rx
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic       clock,
    input  logic       reset_n,
    input  logic       rx,
    output logic [7:0] rx_byte,
    output logic       byte_valid,
    output logic       stop_err
);
    localparam logic [15:0] HALF_LAST = 16'(CLKS_PER_BIT / 2 - 1);
    localparam logic [15:0] BIT_LAST  = 16'(CLKS_PER_BIT - 1);

    logic        rx_meta_reg;
    logic        rxs_reg;
    rx_state_t   state_reg, state_next;
    logic [15:0] cnt_reg, cnt_next;
    logic [2:0]  bit_idx_reg, bit_idx_next;
    logic [7:0]  shift_reg, shift_next;

    // Two-flop synchronizer (idle-high reset) plus FSM/datapath registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
            state_reg   <= IDLE;
            cnt_reg     <= '0;
            bit_idx_reg <= '0;
            shift_reg   <= '0;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
            state_reg   <= state_next;
            cnt_reg     <= cnt_next;
            bit_idx_reg <= bit_idx_next;
            shift_reg   <= shift_next;
        end
    end

    // Bit FSM: half-bit start check, then one sample per bit period, LSB first.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = cnt_reg;
        bit_idx_next = bit_idx_reg;
        shift_next   = shift_reg;
        byte_valid   = 1'b0;
        stop_err     = 1'b0;
        case (state_reg)
            IDLE: begin
                if (!rxs_reg) begin
                    state_next = START;
                    cnt_next   = '0;
                end
            end
            START: begin
                if (cnt_reg == HALF_LAST) begin
                    cnt_next     = '0;
                    bit_idx_next = '0;
                    // A line that has gone high again was only a glitch.
                    state_next   = rxs_reg ? IDLE : DATA;
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DATA: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next     = '0;
                    shift_next   = {rxs_reg, shift_reg[7:1]};
                    bit_idx_next = bit_idx_reg + 3'd1;
                    if (bit_idx_reg == 3'd7) begin
                        state_next = STOP;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            STOP: begin
                if (cnt_reg == BIT_LAST) begin
                    cnt_next = '0;
                    if (rxs_reg) begin
                        byte_valid = 1'b1;
                        state_next = IDLE;
                    end else begin
                        stop_err   = 1'b1;
                        state_next = DRAIN;
                    end
                end else begin
                    cnt_next = cnt_reg + 16'd1;
                end
            end
            DRAIN: begin
                // A low stop bit may be a break; resync only once the line idles.
                if (rxs_reg) begin
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    assign rx_byte = shift_reg;

endmodule

// File: rtl/receive_control.sv
// Receive path of the I/O unit: one-byte holding buffer, sticky error flags
// and the instruction handshake that stalls the CPU until a byte is handed
// over, delivering exactly one byte per receive instruction.
module receive_control
    import uart_pkg::*;
#(
    parameter int CLKS_PER_BIT = DEFAULT_CLKS_PER_BIT
) (
    input  logic clock,
    input  logic reset_n,
    input  logic rx,
    receive_control_if.slave bus
);
    logic [7:0]  rx_byte;
    logic        byte_valid;
    logic        stop_err;

    logic [7:0]  buf_reg, buf_next;
    logic        full_reg, full_next;
    logic [7:0]  rcv_data_reg, rcv_data_next;
    logic        rcv_flag_reg, rcv_flag_next;
    logic        frame_err_reg, frame_err_next;
    logic        overrun_reg, overrun_next;
    ctrl_state_t cstate_reg, cstate_next;
    logic        active;
    logic        deliver;

    uart_rx #(
        .CLKS_PER_BIT(CLKS_PER_BIT)
    ) u_rx (
        .clock      (clock),
        .reset_n    (reset_n),
        .rx         (rx),
        .rx_byte    (rx_byte),
        .byte_valid (byte_valid),
        .stop_err   (stop_err)
    );

    assign active = bus.input_sig_rcv && (bus.opcode == OPCODE_RCV);

    // State, buffer and output registers.
    always_ff @(posedge clock) begin
        if (!reset_n) begin
            cstate_reg    <= C_IDLE;
            buf_reg       <= '0;
            full_reg      <= 1'b0;
            rcv_data_reg  <= '0;
            rcv_flag_reg  <= 1'b0;
            frame_err_reg <= 1'b0;
            overrun_reg   <= 1'b0;
        end else begin
            cstate_reg    <= cstate_next;
            buf_reg       <= buf_next;
            full_reg      <= full_next;
            rcv_data_reg  <= rcv_data_next;
            rcv_flag_reg  <= rcv_flag_next;
            frame_err_reg <= frame_err_next;
            overrun_reg   <= overrun_next;
        end
    end

    // Control FSM: decide when to hand the buffered byte to the instruction.
    always_comb begin
        cstate_next = cstate_reg;
        deliver     = 1'b0;
        case (cstate_reg)
            C_IDLE: begin
                if (active) begin
                    if (full_reg) begin
                        deliver     = 1'b1;
                        cstate_next = C_DONE;
                    end else begin
                        cstate_next = C_WAIT;
                    end
                end
            end
            C_WAIT: begin
                // An instruction that went away never receives the byte.
                if (!active) begin
                    cstate_next = C_IDLE;
                end else if (full_reg) begin
                    deliver     = 1'b1;
                    cstate_next = C_DONE;
                end
            end
            C_DONE: begin
                if (!active) begin
                    cstate_next = C_IDLE;
                end
            end
            default: cstate_next = C_IDLE;
        endcase
    end

    // Buffer and sticky flags; a new event on the delivery edge wins over the clear.
    always_comb begin
        buf_next       = buf_reg;
        full_next      = full_reg;
        rcv_data_next  = rcv_data_reg;
        rcv_flag_next  = deliver;
        frame_err_next = frame_err_reg;
        overrun_next   = overrun_reg;
        if (deliver) begin
            rcv_data_next  = buf_reg;
            full_next      = 1'b0;
            frame_err_next = 1'b0;
            overrun_next   = 1'b0;
        end
        if (byte_valid) begin
            if (!full_reg || deliver) begin
                buf_next  = rx_byte;
                full_next = 1'b1;
            end else begin
                overrun_next = 1'b1;
            end
        end
        if (stop_err) begin
            frame_err_next = 1'b1;
        end
    end

    assign bus.rcv_data  = rcv_data_reg;
    assign bus.rcv_flag  = rcv_flag_reg;
    assign bus.frame_err = frame_err_reg;
    assign bus.overrun   = overrun_reg;
    assign bus.rcv_wait  = active && (cstate_reg != C_DONE) && !rcv_flag_reg;

endmodule

// File: doc/receive_control.md
# receive_control

UART receive path of the CPU's I/O unit, pairing with the send path. Deserializes 8N1 frames from the `rx` pin into a one-byte holding buffer and hands that byte to the datapath only while a receive instruction is executing. The block stalls the CPU until a byte is available and delivers exactly one byte per receive instruction.

## Interface
- `OPCODE_RCV`, 6'b010010: receive instruction opcode.
- `CLKS_PER_BIT`, 434: clock cycles per bit (50 MHz / 115200). Must be ≥ 4.
- `clock`  in  1  system clock; all logic is on the rising edge.
- `reset_n`  in  1  reset. Synchronous, active-low.
- `opcode`  in  6  opcode of the current instruction.
- `input_sig_rcv`  in  1  instruction-valid qualifier. A receive is active when this is 1 and `opcode == OPCODE_RCV`.
- `rx`  in  1  asynchronous serial input; idles high.
- `rcv_data`  out  8  last delivered byte. Registered and held between deliveries.
- `rcv_flag`  out  1  one-cycle pulse when `rcv_data` is updated.
- `rcv_wait`  out  1  stall request to the CPU. Combinational.
- `frame_err`  out  1  sticky: a frame with a low stop bit was dropped.
- `overrun`  out  1  sticky: a byte arrived while the buffer was full and was dropped.

## Operation
- **Synchronizer.** `rx` passes through a 2-FF synchronizer with reset value 1. All logic uses the synchronized value `rxs`.
- **Bit FSM states:** IDLE, START, DATA, STOP, DRAIN.
  - IDLE: on `rxs == 0`, go to START and clear the counter.
  - START: count to `CLKS_PER_BIT/2 - 1`. If `rxs` is still 0, go to DATA. Otherwise it was a glitch; go to IDLE.
  - DATA: sample `rxs` every `CLKS_PER_BIT` cycles, LSB first. After 8 samples, go to STOP.
  - STOP: sample after `CLKS_PER_BIT` cycles.
    - `rxs == 1`: the frame is valid; go to IDLE.
    - `rxs == 0`: set `frame_err` and discard the byte; go to DRAIN.
  - DRAIN: wait for `rxs == 1`, then go to IDLE.
- **Holding buffer:** one byte plus a `full` flag.
  - A valid frame with `full == 0` loads the buffer and sets `full`.
  - A valid frame with `full == 1` sets `overrun`. The old byte is kept and the new byte is dropped.
- **Control FSM states:** C_IDLE, C_WAIT, C_DONE. "Active" means a receive is active.
  - C_IDLE, active, `full == 1`: deliver, go to C_DONE.
  - C_IDLE, active, `full == 0`: go to C_WAIT.
  - C_WAIT, `full == 1`: deliver, go to C_DONE.
  - C_WAIT, no longer active: the instruction was aborted; go to C_IDLE with no delivery.
  - C_DONE: stay until not active, then go to C_IDLE. This limits delivery to one byte per receive instruction, even if the instruction is held for many cycles.
- **Deliver** (all on one edge): `rcv_data <=` buffer, `rcv_flag <= 1` for one cycle, `full <= 0`, and `frame_err` and `overrun` are cleared.
- **Error flags at delivery:** a clear happening on the same edge as a new error set resolves as set. Errors remain visible to the CPU until the next delivery.
- **`rcv_wait`** = active AND control state ≠ C_DONE AND NOT (`rcv_flag`).

## Timing
- **Reset values:** `rcv_data` = 0; `rcv_flag`, `frame_err`, `overrun`, `full` = 0; bit FSM in IDLE; control FSM in C_IDLE; synchronizer flops = 1. `rcv_wait` follows its inputs combinationally.
- **Stop-bit sample** at edge T: `full` = 1 after T. If the control FSM is in C_WAIT, `rcv_flag` = 1 and `rcv_data` is valid after T+1.
- **Buffer already full:** `rcv_flag` is high the cycle after the receive first goes active. `rcv_wait` is high only for that first active cycle.
- **Simultaneous:** delivery on the same edge as a valid frame arriving: the buffer clears and reloads with the new byte, `full` stays 1, and `overrun` is not set.
- **Start-edge latency:** the start edge is seen 2 cycles late because of the synchronizer. Sample points are therefore offset by +2 cycles from the true bit centres, which is acceptable.
- **Reset mid-frame or mid-stall:** everything returns to reset values on the next edge. A partial frame is lost. After reset, the bit FSM sits in IDLE, so a low line is treated as a start bit.

## Structure
- **Shared package `uart_pkg`:** `OPCODE_SND`, `OPCODE_RCV`, default `CLKS_PER_BIT`, and the bit-FSM state encodings.
- **Sub-module `uart_rx`:** synchronizer, bit FSM and bit counter. Outputs a byte, a one-cycle `byte_valid`, and a one-cycle `stop_err`.
- **`receive_control`:** holding buffer, sticky flags and control FSM.

## Test plan
All scenarios use `CLKS_PER_BIT = 16`.
- Send 0xA5 with no receive pending, then issue a receive → `rcv_flag` pulses the cycle after the receive goes active, `rcv_data` = 0xA5, `rcv_wait` high for exactly 1 cycle.
- Issue a receive first, then send 0x3C → `rcv_wait` stays high until 2 cycles after the stop-bit sample, then `rcv_flag` pulses and `rcv_data` = 0x3C.
- Hold a receive active across two frames 0x11 and 0x22 → exactly one `rcv_flag`, `rcv_data` = 0x11. A second receive instruction then yields 0x22.
- Send a frame with the stop bit low, then 0x55, then issue a receive → `frame_err` = 1 before delivery, `rcv_data` = 0x55, `frame_err` = 0 after delivery.
- Send 0x01, 0x02, 0x03 with no receive, then issue a receive → `overrun` = 1 and `rcv_data` = 0x01.
- Pulse `rx` low for 4 cycles → no byte and no flags. Then assert `reset_n` = 0 in the middle of receiving 0xF0 → all outputs return to 0 and no delivery occurs.
